// File: rtl/fifo_lifo_buf.sv
// Single-clock FIFO/LIFO buffer over a simple dual-port word array, with occupancy, status and sticky error flags.
// Optional parity protection of stored words is enabled with FIFO_LIFO_BUF_PARITY_EN.
module fifo_lifo_buf #(
   parameter int dat_width = 32,
   parameter int adr_width = 4,
   parameter int afull_lvl = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode_i,
   input  logic                 push_i,
   input  logic [dat_width-1:0] dat_i,
   input  logic                 pop_i,
   input  logic                 clr_err_i,
   output logic [dat_width-1:0] dat_o,
   output logic                 valid_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic                 afull_o,
   output logic [adr_width:0]   count_o,
   output logic                 ovf_o,
   output logic                 udf_o,
   output logic                 par_err_o
);

   localparam int DEPTH = 2 ** adr_width;
   localparam logic [adr_width:0] C_DEPTH = (adr_width + 1)'(DEPTH);
   localparam logic [adr_width:0] C_AFULL = (adr_width + 1)'(afull_lvl);
`ifdef FIFO_LIFO_BUF_PARITY_EN
   localparam int MW = dat_width + 1;
`else
   localparam int MW = dat_width;
`endif

   logic [MW-1:0]        r_mem [DEPTH];
   logic                 r_mode;
   logic [adr_width-1:0] r_wr_ptr;
   logic [adr_width-1:0] r_rd_ptr;
   logic [adr_width:0]   r_count;
   logic [dat_width-1:0] r_dat;
   logic                 r_valid;
   logic                 r_ovf;
   logic                 r_udf;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_mode;
   logic                 w_push_acc;
   logic                 w_pop_acc;
   logic [adr_width-1:0] w_top;
   logic [adr_width-1:0] w_wr_addr;
   logic [adr_width-1:0] w_rd_addr;
   logic [MW-1:0]        w_wr_word;
   logic [MW-1:0]        w_rd_word;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == C_DEPTH);
   assign w_push_acc = push_i && !w_full;
   assign w_pop_acc  = pop_i && !w_empty;
   // Mode is transparent while empty so the first push already uses the new mode.
   assign w_mode     = w_empty ? mode_i : r_mode;
   // Stack top address; the low bits wrap correctly even at count == depth.
   assign w_top      = r_count[adr_width-1:0] - 1'b1;

   always_comb begin
      w_wr_addr = r_wr_ptr;
      w_rd_addr = r_rd_ptr;
      if (w_mode) begin
         w_rd_addr = w_top;
         w_wr_addr = w_pop_acc ? w_top : r_count[adr_width-1:0];
      end
   end

`ifdef FIFO_LIFO_BUF_PARITY_EN
   logic r_par_err;
   logic w_par_bad;
   assign w_wr_word = {^dat_i, dat_i};
   // A stored word plus its even parity bit always reduces to zero when intact.
   assign w_par_bad = ^w_rd_word;
   always_ff @(posedge clk) begin
      if (!rst_n) r_par_err <= 1'b0;
      else        r_par_err <= (w_pop_acc && w_par_bad) || (r_par_err && !clr_err_i);
   end
   assign par_err_o = r_par_err;
`else
   assign w_wr_word = dat_i;
   assign par_err_o = 1'b0;
`endif

   assign w_rd_word = r_mem[w_rd_addr];

   always_ff @(posedge clk) begin
      if (w_push_acc) r_mem[w_wr_addr] <= w_wr_word;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode   <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dat    <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_empty) r_mode <= mode_i;
         if (w_push_acc && !w_mode) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_acc && !w_mode)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_acc, w_pop_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_valid <= w_pop_acc;
         if (w_pop_acc) r_dat <= w_rd_word[dat_width-1:0];
         // A set event in the same cycle wins over the clear.
         r_ovf <= (push_i && w_full) || (r_ovf && !clr_err_i);
         r_udf <= (pop_i && w_empty) || (r_udf && !clr_err_i);
      end
   end

   assign dat_o   = r_dat;
   assign valid_o = r_valid;
   assign empty_o = w_empty;
   assign full_o  = w_full;
   assign afull_o = (r_count >= C_AFULL);
   assign count_o = r_count;
   assign ovf_o   = r_ovf;
   assign udf_o   = r_udf;

endmodule
